// File: rtl/kernel_sdram_ex_pkg.sv
// Shared types and helpers for the SDRAM example LFSR read-back checker.
// Holds the FSM state encoding and the x^8+x^4+x^3+x^2+1 Galois step.
package kernel_sdram_ex_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        FIN   = 2'd2
    } state_t;

    localparam logic [7:0] LFSR_TAPS = 8'h1D;

    function automatic logic [7:0] lfsr8_next(input logic [7:0] e);
        return {e[6:0], 1'b0} ^ (e[7] ? LFSR_TAPS : 8'h00);
    endfunction

endpackage

// File: rtl/kernel_sdram_ex_lfsr8_exp.sv
// Expected-value register for the LFSR checker.
// A load takes priority over an advance in the same cycle.
module kernel_sdram_ex_lfsr8_exp
    import kernel_sdram_ex_pkg::*;
#(
    parameter logic [7:0] SEED = 8'h20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_value,
    input  logic       advance,
    output logic [7:0] exp_value
);

    always_ff @(posedge clk) begin
        if (reset) begin
            exp_value <= SEED;
        end else if (load) begin
            exp_value <= load_value;
        end else if (advance) begin
            exp_value <= lfsr8_next(exp_value);
        end
    end

endmodule

// File: rtl/kernel_sdram_ex_lfsr8_checker.sv
// Checks a read-back beat stream against an 8-bit Galois LFSR sequence,
// counting mismatches and latching details of the first one in each run.
module kernel_sdram_ex_lfsr8_checker
    import kernel_sdram_ex_pkg::*;
#(
    parameter int ERR_W     = 16,
    parameter int SEED      = 32,
    parameter bit SELF_SYNC = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [15:0]      length,
    input  logic             valid,
    input  logic [7:0]       data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [15:0]      first_err_idx,
    output logic [7:0]       first_err_exp,
    output logic [7:0]       first_err_got
);

    localparam logic [7:0] SEED8 = SEED[7:0];

    state_t      state;
    state_t      state_next;
    logic [15:0] len_q;
    logic [15:0] beat_idx;
    logic        first_err_seen;
    logic [7:0]  exp_value;

    logic accept_start;
    logic beat;
    logic sync_beat;
    logic mismatch;
    logic last_beat;
    logic exp_load;
    logic exp_advance;
    logic [7:0] exp_load_value;

    // abort outranks both start (in IDLE) and valid (in CHECK)
    assign accept_start = (state == IDLE) && start && !abort;
    assign beat         = (state == CHECK) && valid && !abort;
    assign sync_beat    = SELF_SYNC && (beat_idx == 16'd0);
    assign mismatch     = beat && !sync_beat && (data != exp_value);
    assign last_beat    = beat && (beat_idx == len_q - 16'd1);

    assign exp_load       = (accept_start && (length != 16'd0)) || (beat && sync_beat);
    assign exp_load_value = accept_start ? SEED8 : lfsr8_next(data);
    assign exp_advance    = beat && !sync_beat;

    kernel_sdram_ex_lfsr8_exp #(
        .SEED(SEED8)
    ) u_exp (
        .clk       (clk),
        .reset     (reset),
        .load      (exp_load),
        .load_value(exp_load_value),
        .advance   (exp_advance),
        .exp_value (exp_value)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept_start) state_next = (length == 16'd0) ? FIN : CHECK;
            CHECK:   if (abort) state_next = IDLE;
                     else if (last_beat) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == CHECK);
    assign done = (state == FIN);

    // pass is settled on the edge into FIN so it is already valid while done is high
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q          <= '0;
            beat_idx       <= '0;
            err_count      <= '0;
            first_err_seen <= 1'b0;
            first_err_idx  <= '0;
            first_err_exp  <= '0;
            first_err_got  <= '0;
            pass           <= 1'b0;
        end else begin
            if (accept_start) begin
                len_q          <= length;
                beat_idx       <= '0;
                err_count      <= '0;
                first_err_seen <= 1'b0;
                first_err_idx  <= '0;
                first_err_exp  <= '0;
                first_err_got  <= '0;
                if (length == 16'd0) begin
                    pass <= 1'b1;
                end
            end
            if (beat) begin
                beat_idx <= beat_idx + 16'd1;
                if (mismatch) begin
                    if (err_count != '1) begin
                        err_count <= err_count + ERR_W'(1);
                    end
                    if (!first_err_seen) begin
                        first_err_seen <= 1'b1;
                        first_err_idx  <= beat_idx;
                        first_err_exp  <= exp_value;
                        first_err_got  <= data;
                    end
                end
                if (last_beat) begin
                    pass <= (err_count == '0) && !mismatch;
                end
            end
        end
    end

endmodule
